// File: rtl/egress_frame_arbiter.sv
// Frame-granular arbiter: shares one egress byte stream among N_REQ queues, whole frames only.
// Build macro EGRESS_ARB_STRICT_PRIORITY_EN selects PCP priority; otherwise pure round-robin.
package ethernet_pkg;
  localparam int N_OF_BYTE_FRAME_MAX     = 1526;
  localparam int FRAME_SIZE_BIT_WIDTH    = 11;
  localparam int VLAN_PRIORITY_BIT_WIDTH = 3;
endpackage

module egress_frame_arbiter
  import ethernet_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int IFG_CYCLES      = 12,
  parameter int MAX_FRAME_BYTES = N_OF_BYTE_FRAME_MAX
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [N_REQ-1:0]                           req_valid,
  input  logic [N_REQ*8-1:0]                         req_data,
  input  logic [N_REQ-1:0]                           req_last,
  input  logic [N_REQ*VLAN_PRIORITY_BIT_WIDTH-1:0]   req_pcp,
  output logic [N_REQ-1:0]                           req_ready,
  output logic                                       tx_valid,
  output logic [7:0]                                 tx_data,
  output logic                                       tx_last,
  input  logic                                       tx_ready,
  output logic                                       grant_valid,
  output logic [$clog2(N_REQ)-1:0]                   grant_id,
  output logic                                       oversize_err
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = FRAME_SIZE_BIT_WIDTH;
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_GAP} state_t;

  // With no inter-frame gap the arbiter returns straight to IDLE after a frame.
  localparam state_t END_STATE = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]   grant_id_reg, grant_id_next;
  logic [CNT_W-1:0]  byte_cnt_reg, byte_cnt_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;

  logic [7:0]        req_byte [N_REQ];
  logic [ID_W-1:0]   winner;
  logic              win_found;
  logic              win_take;
  logic [ID_W:0]     win_sum;
  logic [ID_W-1:0]   win_idx;
  logic              g_valid;
  logic              g_last;
  logic              truncate;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack_data
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

`ifdef EGRESS_ARB_STRICT_PRIORITY_EN
  logic [VLAN_PRIORITY_BIT_WIDTH-1:0] req_prio [N_REQ];
  logic [VLAN_PRIORITY_BIT_WIDTH-1:0] win_best;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack_pcp
      assign req_prio[gi] = req_pcp[VLAN_PRIORITY_BIT_WIDTH*gi +: VLAN_PRIORITY_BIT_WIDTH];
    end
  endgenerate

  // Scan circularly from rr_ptr; a strictly higher PCP is needed to displace an earlier hit.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    win_take  = 1'b0;
    win_best  = '0;
    win_sum   = '0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      win_sum = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
      if (win_sum >= (ID_W+1)'(N_REQ)) win_sum = win_sum - (ID_W+1)'(N_REQ);
      win_idx  = win_sum[ID_W-1:0];
      win_take = req_valid[win_idx] && (!win_found || (req_prio[win_idx] > win_best));
      if (win_take) begin
        win_found = 1'b1;
        win_best  = req_prio[win_idx];
        winner    = win_idx;
      end
    end
  end
`else
  logic unused_pcp;
  assign unused_pcp = ^req_pcp;

  // First valid requester at or after rr_ptr, circularly.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    win_take  = 1'b0;
    win_sum   = '0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      win_sum = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
      if (win_sum >= (ID_W+1)'(N_REQ)) win_sum = win_sum - (ID_W+1)'(N_REQ);
      win_idx  = win_sum[ID_W-1:0];
      win_take = req_valid[win_idx] && !win_found;
      if (win_take) begin
        win_found = 1'b1;
        winner    = win_idx;
      end
    end
  end
`endif

  assign g_valid  = req_valid[grant_id_reg];
  assign g_last   = req_last[grant_id_reg];
  assign truncate = (byte_cnt_reg == CNT_W'(MAX_FRAME_BYTES - 1)) && !g_last;
  assign grant_id = grant_id_reg;

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    grant_id_next = grant_id_reg;
    byte_cnt_next = byte_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    req_ready     = '0;
    tx_valid      = 1'b0;
    tx_data       = '0;
    tx_last       = 1'b0;
    grant_valid   = 1'b0;
    oversize_err  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (|req_valid) begin
          grant_id_next = winner;
          rr_ptr_next   = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
          byte_cnt_next = '0;
          state_next    = S_XFER;
        end
      end
      S_XFER: begin
        grant_valid             = 1'b1;
        tx_valid                = g_valid;
        tx_data                 = req_byte[grant_id_reg];
        tx_last                 = g_last | truncate;
        req_ready[grant_id_reg] = tx_ready;
        if (g_valid && tx_ready) begin
          byte_cnt_next = byte_cnt_reg + 1'b1;
          oversize_err  = truncate;
          if (truncate) begin
            state_next = S_DRAIN;
          end else if (g_last) begin
            state_next   = END_STATE;
            gap_cnt_next = GAP_LOAD;
          end
        end
      end
      S_DRAIN: begin
        // Swallow the rest of a truncated frame without presenting it downstream.
        grant_valid             = 1'b1;
        req_ready[grant_id_reg] = 1'b1;
        if (g_valid && g_last) begin
          state_next   = END_STATE;
          gap_cnt_next = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == '0) state_next = S_IDLE;
        else gap_cnt_next = gap_cnt_reg - 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      rr_ptr_reg   <= '0;
      grant_id_reg <= '0;
      byte_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      grant_id_reg <= grant_id_next;
      byte_cnt_reg <= byte_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
    end
  end

endmodule

// File: tb/tb_egress_frame_arbiter.sv
// Directed bench for egress_frame_arbiter: requester byte-stream models, egress log, hand-derived expectations.
`timescale 1ns/1ps
module tb_egress_frame_arbiter;
  localparam int N    = 4;
  localparam int IFG  = 12;
  localparam int MAXB = 1526;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N*3-1:0] req_pcp;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_last;
  logic           tx_ready;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic           oversize_err;

  always #5 clk = ~clk;

  egress_frame_arbiter #(.N_REQ(N), .IFG_CYCLES(IFG), .MAX_FRAME_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_pcp(req_pcp),
    .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .grant_valid(grant_valid), .grant_id(grant_id), .oversize_err(oversize_err)
  );

  int         frm_q [N][$];
  int         pos [N];
  int         acc_cnt [N];
  logic [7:0] log_data [$];
  bit         log_last [$];
  int         log_gid [$];
  int         log_cyc [$];
  int         cyc_no, n_checks, n_fail;
  int         ovs_cnt, ovs_cyc, ready_viol, frame_bytes;
  bit         rand_ready;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (frm_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int data_errors();
    int e = 0;
    int ep [N];
    for (int i = 0; i < N; i++) ep[i] = 0;
    foreach (log_data[k]) begin
      if (log_data[k] !== 8'(ep[log_gid[k]] + 64 * log_gid[k])) e++;
      if (log_last[k]) ep[log_gid[k]] = 0;
      else ep[log_gid[k]]++;
    end
    return e;
  endfunction

  function automatic int last_count();
    int c = 0;
    foreach (log_last[k]) if (log_last[k]) c++;
    return c;
  endfunction

  task automatic clear_log();
    log_data.delete(); log_last.delete(); log_gid.delete(); log_cyc.delete();
    ovs_cnt = 0; ovs_cyc = -1; ready_viol = 0; frame_bytes = 0;
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (frm_q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = 8'(pos[i] + 64 * i);
        req_last[i]        = (pos[i] == frm_q[i][0] - 1);
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // One clock: drive at the falling edge, observe combinational outputs 1ns later.
  task automatic cyc();
    @(negedge clk);
    drive();
    #1;
    if (tx_valid && tx_ready) begin
      log_data.push_back(tx_data);
      log_last.push_back(tx_last);
      log_gid.push_back(int'(grant_id));
      log_cyc.push_back(cyc_no);
      frame_bytes++;
      if (tx_last) begin
        $display("tx frame: grant_id=%0d bytes=%0d end_cycle=%0d", grant_id, frame_bytes, cyc_no);
        frame_bytes = 0;
      end
    end
    if (oversize_err) begin
      ovs_cnt++;
      ovs_cyc = cyc_no;
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && (!grant_valid || i != int'(grant_id))) ready_viol++;
      if (req_valid[i] && req_ready[i]) begin
        acc_cnt[i]++;
        pos[i]++;
        if (pos[i] == frm_q[i][0]) begin
          void'(frm_q[i].pop_front());
          pos[i] = 0;
        end
      end
    end
    cyc_no++;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while (!all_empty() && n < budget) begin
      cyc();
      n++;
    end
    check_value({tag, "_done"}, 32'(all_empty()), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_value({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check_value({tag, "_tx_last"}, 32'(tx_last), 32'd0);
    check_value({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check_value({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_value({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
    check_value({tag, "_oversize_err"}, 32'(oversize_err), 32'd0);
    check_value({tag, "_grant_id"}, 32'(grant_id), 32'd0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n, first_id, second_id;
    n_checks = 0; n_fail = 0; cyc_no = 0; rand_ready = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; req_pcp = '0; tx_ready = 1'b1;
    for (int i = 0; i < N; i++) pos[i] = 0;
    clear_log();

    // Reset state
    rst = 1'b1;
    repeat (3) cyc();
    check_idle_outputs("reset");
    rst = 1'b0;

    // Single 64-byte frame from req0
    clear_log();
    frm_q[0].push_back(64);
    c0 = cyc_no;
    run_until_done("single", 300);
    check_value("single_count", 32'(log_data.size()), 32'd64);
    check_value("single_data_err", 32'(data_errors()), 32'd0);
    check_value("single_last_cnt", 32'(last_count()), 32'd1);
    check_value("single_last_pos", 32'(log_last[63]), 32'd1);
    check_value("single_gid", 32'(log_gid[0]), 32'd0);
    check_value("single_latency", 32'(log_cyc[0] - c0), 32'd1);
    check_value("single_ready_viol", 32'(ready_viol), 32'd0);
    repeat (IFG + 4) cyc();

    // Priority: req1 pcp=2, req3 pcp=5, requested together
    clear_log();
    req_pcp = {3'd5, 3'd0, 3'd2, 3'd0};
    frm_q[1].push_back(8);
    frm_q[3].push_back(8);
    run_until_done("prio", 300);
`ifdef EGRESS_ARB_STRICT_PRIORITY_EN
    first_id = 3; second_id = 1;
`else
    first_id = 1; second_id = 3;
`endif
    check_value("prio_count", 32'(log_data.size()), 32'd16);
    check_value("prio_first", 32'(log_gid[0]), 32'(first_id));
    check_value("prio_second", 32'(log_gid[8]), 32'(second_id));
    check_value("prio_gap", 32'(log_cyc[8] - log_cyc[7]), 32'(IFG + 2));
    check_value("prio_data_err", 32'(data_errors()), 32'd0);
    repeat (IFG + 4) cyc();

    // Round-robin tie after a reset: 3 frames per requester, all pcp 0
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req_pcp = '0;
    clear_log();
    for (int i = 0; i < N; i++) repeat (3) frm_q[i].push_back(4);
    run_until_done("rr", 1000);
    check_value("rr_count", 32'(log_data.size()), 32'd48);
    for (int k = 0; k < 12; k++)
      check_value($sformatf("rr_order_%0d", k), 32'(log_gid[4*k]), 32'(k % 4));
    check_value("rr_data_err", 32'(data_errors()), 32'd0);
    repeat (IFG + 4) cyc();

    // Backpressure: random tx_ready, req1 100 bytes then req3 5 bytes
    clear_log();
    rand_ready = 1'b1;
    frm_q[1].push_back(100);
    frm_q[3].push_back(5);
    run_until_done("bp", 2000);
    rand_ready = 1'b0;
    check_value("bp_count", 32'(log_data.size()), 32'd105);
    check_value("bp_accepted", 32'(acc_cnt[1]), 32'd100);
    check_value("bp_data_err", 32'(data_errors()), 32'd0);
    check_value("bp_last_cnt", 32'(last_count()), 32'd2);
    check_value("bp_first_gid", 32'(log_gid[0]), 32'd1);
    check_value("bp_second_gid", 32'(log_gid[100]), 32'd3);
    check_value("bp_ready_viol", 32'(ready_viol), 32'd0);
    repeat (IFG + 4) cyc();

    // Oversize: req2 sends 1600 bytes, truncated at 1526
    clear_log();
    frm_q[2].push_back(1600);
    run_until_done("ovs", 3000);
    check_value("ovs_tx_count", 32'(log_data.size()), 32'(MAXB));
    check_value("ovs_forced_last", 32'(log_last[MAXB-1]), 32'd1);
    check_value("ovs_last_cnt", 32'(last_count()), 32'd1);
    check_value("ovs_pulse_cnt", 32'(ovs_cnt), 32'd1);
    check_value("ovs_pulse_cycle", 32'(ovs_cyc), 32'(log_cyc[MAXB-1]));
    check_value("ovs_accepted", 32'(acc_cnt[2]), 32'd1600);
    check_value("ovs_data_err", 32'(data_errors()), 32'd0);
    cyc();
    check_value("ovs_gap_grant", 32'(grant_valid), 32'd0);
    check_value("ovs_gap_ready", 32'(req_ready), 32'd0);
    repeat (IFG + 4) cyc();

    // Reset in the middle of a frame, after 30 bytes
    clear_log();
    frm_q[0].push_back(64);
    n = 0;
    while (log_data.size() < 30 && n < 200) begin
      cyc();
      n++;
    end
    check_value("midrst_progress", 32'(log_data.size()), 32'd30);
    check_value("midrst_no_last", 32'(last_count()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    frm_q[0].delete();
    pos[0] = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    clear_log();
    frm_q[1].push_back(8);
    c0 = cyc_no;
    run_until_done("midrst_new", 200);
    check_value("midrst_new_count", 32'(log_data.size()), 32'd8);
    check_value("midrst_new_gid", 32'(log_gid[0]), 32'd1);
    check_value("midrst_new_latency", 32'(log_cyc[0] - c0), 32'd1);
    check_value("midrst_new_data_err", 32'(data_errors()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
